// File: rtl/colormix_pkg.sv
// rtl/colormix_pkg.sv - shared constants and types for the ColorMix key entry path
// Purpose: key map constants, FSM state encoding and channel-select encodings
//          used by key_color_entry and its debouncer.
// Ports:   none (package).
package colormix_pkg;

  localparam logic [3:0] KEY_SEL_R  = 4'hA;
  localparam logic [3:0] KEY_SEL_G  = 4'hB;
  localparam logic [3:0] KEY_SEL_B  = 4'hC;
  localparam logic [3:0] KEY_CLR    = 4'hD;
  localparam logic [3:0] KEY_CANCEL = 4'hE;
  localparam logic [3:0] KEY_ENTER  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] CHAN_NONE = 2'b00;
  localparam logic [1:0] CHAN_R    = 2'b01;
  localparam logic [1:0] CHAN_G    = 2'b10;
  localparam logic [1:0] CHAN_B    = 2'b11;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  function automatic logic is_sel(input logic [3:0] k);
    return (k == KEY_SEL_R) || (k == KEY_SEL_G) || (k == KEY_SEL_B);
  endfunction

  // Only meaningful for the three select keys.
  function automatic logic [1:0] sel_to_chan(input logic [3:0] k);
    if (k == KEY_SEL_R) return CHAN_R;
    if (k == KEY_SEL_G) return CHAN_G;
    return CHAN_B;
  endfunction

endpackage

// File: rtl/key_event_debouncer.sv
// rtl/key_event_debouncer.sv - key_done synchroniser, debouncer and key code latch
// Purpose: turns the asynchronous keypad flag into one clean event per press.
// Ports:
//   i_clk       in  1  system clock
//   i_rst_n     in  1  asynchronous active-low reset
//   i_key_done  in  1  raw keypad key-detected flag (asynchronous)
//   i_key_code  in  4  key code, valid while i_key_done is high
//   o_key_evt   out 1  one-cycle event pulse
//   o_key_q     out 4  key code captured with the event
module key_event_debouncer #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key_done,
  input  logic [3:0] i_key_code,
  output logic       o_key_evt,
  output logic [3:0] o_key_q
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic             r_evt;
  logic [3:0]       r_key;
  logic             w_synced;

  assign w_synced = r_sync[1];

  // Armed: count consecutive high cycles, fire on the last one and disarm.
  // Disarmed: count consecutive low cycles before re-arming. Any sample at
  // the wrong level restarts the count, so bounces never accumulate.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b00;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_evt   <= 1'b0;
      r_key   <= 4'h0;
    end else begin
      r_sync <= {r_sync[0], i_key_done};
      r_evt  <= 1'b0;
      if (r_armed) begin
        if (w_synced) begin
          if (r_cnt == CNT_LAST) begin
            r_evt   <= 1'b1;
            r_key   <= i_key_code;
            r_armed <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end else begin
        if (!w_synced) begin
          if (r_cnt == CNT_LAST) begin
            r_armed <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

  assign o_key_evt = r_evt;
  assign o_key_q   = r_key;

endmodule

// File: rtl/key_color_entry.sv
// rtl/key_color_entry.sv - keystroke-to-RGB entry FSM for the ColorMix datapath
// Purpose: selects a channel, accumulates up to three decimal digits with
//          saturation, and commits the value into the {R,G,B} colour register.
// Ports:
//   clk50        in  1         system clock
//   rst_n        in  1         asynchronous active-low reset
//   key_code     in  4         keypad code, valid while key_done is high
//   key_done     in  1         keypad key-detected flag (asynchronous)
//   color        out 3*CHAN_W  committed colour {R,G,B}
//   color_valid  out 1         one-cycle pulse on commit
//   chan_sel     out 2         current channel (00 none, 01 R, 10 G, 11 B)
//   entry_val    out CHAN_W    live accumulator
//   err          out 1         one-cycle pulse on rejected key or timeout
module key_color_entry
  import colormix_pkg::*;
#(
  parameter int CHAN_W     = 8,
  parameter int DEB_CYCLES = 16,
  parameter int TIMEOUT    = 250_000_000
) (
  input  logic                  clk50,
  input  logic                  rst_n,
  input  logic [3:0]            key_code,
  input  logic                  key_done,
  output logic [3*CHAN_W-1:0]   color,
  output logic                  color_valid,
  output logic [1:0]            chan_sel,
  output logic [CHAN_W-1:0]     entry_val,
  output logic                  err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TIMEOUT - 1);
  localparam logic [CHAN_W+3:0]   ACC_MAX_EXT = {4'b0000, {CHAN_W{1'b1}}};

  logic                w_key_evt;
  logic [3:0]          w_key_q;

  state_t              r_state,   w_state_nxt;
  logic [1:0]          r_chan,    w_chan_nxt;
  logic [CHAN_W-1:0]   r_acc,     w_acc_nxt;
  logic [1:0]          r_ndig,    w_ndig_nxt;
  logic [TMO_W-1:0]    r_tmo,     w_tmo_nxt;
  logic [3*CHAN_W-1:0] r_color,   w_color_nxt;
  logic                r_valid,   w_valid_nxt;
  logic                r_err,     w_err_nxt;
  logic                r_pend,    w_pend_nxt;
  logic [3:0]          r_pend_key, w_pend_key_nxt;

  logic                w_evt;
  logic [3:0]          w_key;
  logic [CHAN_W+3:0]   w_prod;
  logic [CHAN_W-1:0]   w_acc_sat;

  key_event_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .i_clk      (clk50),
    .i_rst_n    (rst_n),
    .i_key_done (key_done),
    .i_key_code (key_code),
    .o_key_evt  (w_key_evt),
    .o_key_q    (w_key_q)
  );

  // An event that lands during COMMIT is parked and replayed in IDLE.
  assign w_evt = w_key_evt | r_pend;
  assign w_key = r_pend ? r_pend_key : w_key_q;

  // Wide enough that 255*10+9 cannot wrap before saturation.
  assign w_prod    = {4'b0000, r_acc} * (CHAN_W+4)'(10) + (CHAN_W+4)'(w_key);
  assign w_acc_sat = (w_prod > ACC_MAX_EXT) ? {CHAN_W{1'b1}} : w_prod[CHAN_W-1:0];

  always_comb begin
    w_state_nxt    = r_state;
    w_chan_nxt     = r_chan;
    w_acc_nxt      = r_acc;
    w_ndig_nxt     = r_ndig;
    w_tmo_nxt      = '0;
    w_color_nxt    = r_color;
    w_valid_nxt    = 1'b0;
    w_err_nxt      = 1'b0;
    w_pend_nxt     = 1'b0;
    w_pend_key_nxt = r_pend_key;

    case (r_state)
      ST_IDLE: begin
        if (w_evt) begin
          if (is_sel(w_key)) begin
            w_state_nxt = ST_ENTRY;
            w_chan_nxt  = sel_to_chan(w_key);
            w_acc_nxt   = '0;
            w_ndig_nxt  = 2'd0;
          end else if (w_key != KEY_CANCEL) begin
            w_err_nxt = 1'b1;
          end
        end
      end

      ST_ENTRY: begin
        w_tmo_nxt = r_tmo + TMO_W'(1);
        if (w_evt) begin
          w_tmo_nxt = '0;
          if (is_digit(w_key)) begin
            if (r_ndig == 2'd3) begin
              w_err_nxt = 1'b1;
            end else begin
              w_acc_nxt  = w_acc_sat;
              w_ndig_nxt = r_ndig + 2'd1;
            end
          end else if (is_sel(w_key)) begin
            w_chan_nxt = sel_to_chan(w_key);
            w_acc_nxt  = '0;
            w_ndig_nxt = 2'd0;
          end else if (w_key == KEY_CLR) begin
            w_acc_nxt  = '0;
            w_ndig_nxt = 2'd0;
          end else if (w_key == KEY_CANCEL) begin
            w_state_nxt = ST_IDLE;
            w_chan_nxt  = CHAN_NONE;
            w_acc_nxt   = '0;
            w_ndig_nxt  = 2'd0;
          end else begin
            if (r_ndig == 2'd0) begin
              w_err_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_COMMIT;
            end
          end
        end else if (r_tmo == TMO_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
          w_chan_nxt  = CHAN_NONE;
          w_acc_nxt   = '0;
          w_ndig_nxt  = 2'd0;
          w_tmo_nxt   = '0;
        end
      end

      ST_COMMIT: begin
        case (r_chan)
          CHAN_R:  w_color_nxt[3*CHAN_W-1 -: CHAN_W] = r_acc;
          CHAN_G:  w_color_nxt[2*CHAN_W-1 -: CHAN_W] = r_acc;
          CHAN_B:  w_color_nxt[CHAN_W-1:0]           = r_acc;
          default: w_color_nxt = r_color;
        endcase
        w_valid_nxt = 1'b1;
        w_chan_nxt  = CHAN_NONE;
        w_acc_nxt   = '0;
        w_ndig_nxt  = 2'd0;
        w_state_nxt = ST_IDLE;
        if (w_key_evt) begin
          w_pend_nxt     = 1'b1;
          w_pend_key_nxt = w_key_q;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_chan_nxt  = CHAN_NONE;
        w_acc_nxt   = '0;
        w_ndig_nxt  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_chan     <= CHAN_NONE;
      r_acc      <= '0;
      r_ndig     <= 2'd0;
      r_tmo      <= '0;
      r_color    <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_key <= 4'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_chan     <= w_chan_nxt;
      r_acc      <= w_acc_nxt;
      r_ndig     <= w_ndig_nxt;
      r_tmo      <= w_tmo_nxt;
      r_color    <= w_color_nxt;
      r_valid    <= w_valid_nxt;
      r_err      <= w_err_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_key <= w_pend_key_nxt;
    end
  end

  assign color       = r_color;
  assign color_valid = r_valid;
  assign chan_sel    = r_chan;
  assign entry_val   = r_acc;
  assign err         = r_err;

endmodule

// File: tb/tb_key_color_entry.sv
// tb/tb_key_color_entry.sv - directed self-checking bench for key_color_entry
module tb_key_color_entry;

  logic        clk50;
  logic        rst_n;
  logic [3:0]  key_code;
  logic        key_done;
  logic [23:0] color;
  logic        color_valid;
  logic [1:0]  chan_sel;
  logic [7:0]  entry_val;
  logic        err;

  int n_checks;
  int n_pass;
  int n_valid;
  int n_err;
  int base_valid;
  int base_err;

  key_color_entry #(.CHAN_W(8), .DEB_CYCLES(4), .TIMEOUT(1000)) dut (
    .clk50       (clk50),
    .rst_n       (rst_n),
    .key_code    (key_code),
    .key_done    (key_done),
    .color       (color),
    .color_valid (color_valid),
    .chan_sel    (chan_sel),
    .entry_val   (entry_val),
    .err         (err)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  initial begin
    n_valid = 0;
    n_err   = 0;
  end

  always @(negedge clk50) begin
    if (color_valid) n_valid++;
    if (err)         n_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic press(input logic [3:0] code);
    @(negedge clk50);
    key_code = code;
    key_done = 1'b1;
    repeat (10) @(negedge clk50);
    key_done = 1'b0;
    repeat (10) @(negedge clk50);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk50);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    key_code = 4'h0;
    key_done = 1'b0;
    idle(3);
    check("rst_color", 32'(color), 32'h0);
    check("rst_chan",  32'(chan_sel), 32'h0);
    check("rst_entry", 32'(entry_val), 32'h0);
    check("rst_valid", 32'(color_valid), 32'h0);
    check("rst_err",   32'(err), 32'h0);
    rst_n = 1'b1;
    idle(10);

    // R = 255 via A,2,5,5,F
    base_valid = n_valid;
    press(4'hA);
    check("selR_chan", 32'(chan_sel), 32'h1);
    press(4'h2); press(4'h5); press(4'h5);
    check("r_entry255", 32'(entry_val), 32'd255);
    press(4'hF);
    check("r_color", 32'(color), 32'hFF0000);
    check("r_valid_cnt", 32'(n_valid - base_valid), 32'd1);
    check("r_chan_after", 32'(chan_sel), 32'h0);
    check("r_entry_after", 32'(entry_val), 32'h0);

    // G saturates: 300 -> 255
    press(4'hB); press(4'h3); press(4'h0); press(4'h0);
    check("g_sat", 32'(entry_val), 32'd255);
    press(4'hF);
    check("g_color", 32'(color), 32'hFFFF00);

    // 4th digit rejected
    press(4'hB); press(4'h1); press(4'h2); press(4'h3);
    check("e123", 32'(entry_val), 32'd123);
    base_err = n_err;
    press(4'h4);
    check("d4_err", 32'(n_err - base_err), 32'd1);
    check("d4_entry", 32'(entry_val), 32'd123);
    press(4'hE);
    check("cancel_chan", 32'(chan_sel), 32'h0);
    check("cancel_color", 32'(color), 32'hFFFF00);

    // bounce: only the final long hold produces one digit
    press(4'hC);
    @(negedge clk50);
    key_code = 4'h7;
    for (int i = 0; i < 10; i++) begin
      key_done = ~key_done;
      repeat (2) @(negedge clk50);
    end
    key_done = 1'b1;
    idle(10);
    key_done = 1'b0;
    idle(10);
    check("bounce_entry", 32'(entry_val), 32'd7);
    press(4'hE);

    // timeout after C,7
    press(4'hC); press(4'h7);
    base_err = n_err;
    idle(950);
    check("tmo_early", 32'(n_err - base_err), 32'd0);
    check("tmo_early_chan", 32'(chan_sel), 32'h3);
    idle(100);
    check("tmo_err", 32'(n_err - base_err), 32'd1);
    check("tmo_chan", 32'(chan_sel), 32'h0);
    check("tmo_entry", 32'(entry_val), 32'h0);
    check("tmo_color", 32'(color), 32'hFFFF00);

    // errors in IDLE
    base_err = n_err;
    press(4'h5);
    check("idle_digit_err", 32'(n_err - base_err), 32'd1);
    check("idle_digit_chan", 32'(chan_sel), 32'h0);
    press(4'hF);
    check("idle_f_err", 32'(n_err - base_err), 32'd2);
    press(4'hE);
    check("idle_e_noerr", 32'(n_err - base_err), 32'd2);

    // C,F -> err, stays in ENTRY, then 4,F commits blue
    press(4'hC);
    base_err = n_err;
    press(4'hF);
    check("cf_err", 32'(n_err - base_err), 32'd1);
    check("cf_chan", 32'(chan_sel), 32'h3);
    base_valid = n_valid;
    press(4'h4); press(4'hF);
    check("b_color", 32'(color), 32'hFFFF04);
    check("b_valid_cnt", 32'(n_valid - base_valid), 32'd1);

    // reset mid-entry
    press(4'hA); press(4'h9);
    check("pre_rst_entry", 32'(entry_val), 32'd9);
    base_valid = n_valid;
    @(negedge clk50);
    rst_n = 1'b0;
    #1;
    check("mid_rst_color", 32'(color), 32'h0);
    check("mid_rst_chan",  32'(chan_sel), 32'h0);
    check("mid_rst_entry", 32'(entry_val), 32'h0);
    @(negedge clk50);
    rst_n = 1'b1;
    idle(20);
    check("post_rst_valid", 32'(n_valid - base_valid), 32'd0);
    check("post_rst_color", 32'(color), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
